// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, frame debounce, valid/ready key events.
// Define KEYPAD_HEXMAP_EN to emit the 4x4 hex legend instead of the raw index.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_TICKS     = 100000,
    parameter int SETTLE_TICKS   = 8,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            key_overrun
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

`ifdef KEYPAD_HEXMAP_EN
    localparam logic [63:0] HEX_LUT = 64'hDEF0_C987_B654_A321;

    if (ROWS != 4 || COLS != 4) begin : g_hexmap_size
        $error("KEYPAD_HEXMAP_EN requires ROWS=4 and COLS=4");
    end

    function automatic logic [KW-1:0] to_code(input logic [KW-1:0] i);
        return KW'(HEX_LUT[{i, 2'b00} +: 4]);
    endfunction
`else
    function automatic logic [KW-1:0] to_code(input logic [KW-1:0] i);
        return i;
    endfunction
`endif

    logic [TW-1:0]   tick_q, tick_d;
    logic [CW-1:0]   c_q, c_d;
    logic [COLS-1:0] col_q, col_d;
    logic            fnone_q, fnone_d;
    logic [KW-1:0]   fidx_q, fidx_d;
    logic            pnone_q, pnone_d;
    logic [KW-1:0]   pidx_q, pidx_d;
    logic            dnone_q, dnone_d;
    logic [KW-1:0]   didx_q, didx_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic            evt_q, evt_d;
    logic [KW-1:0]   ecode_q, ecode_d;
    logic            held_q, held_d;
    logic            valid_q, valid_d;
    logic [KW-1:0]   code_q, code_d;
    logic            ovr_q, ovr_d;

    logic            last_tick;
    logic            wrap;
    logic            sample;
    logic            lnone;
    logic [KW-1:0]   lidx;
    logic            same_prev;
    logic            same_deb;

    always_comb begin
        last_tick = (tick_q == TW'(SCAN_TICKS - 1));
        wrap      = last_tick && (c_q == CW'(COLS - 1));
        sample    = (tick_q == TW'(SETTLE_TICKS));

        tick_d = last_tick ? '0 : tick_q + TW'(1);
        c_d    = c_q;
        if (last_tick) begin
            c_d = (c_q == CW'(COLS - 1)) ? '0 : c_q + CW'(1);
        end
        col_d = ~(COLS'(1) << (CW'(COLS - 1) - c_d));

        // Descending loop leaves the lowest pressed row of this column.
        lnone = 1'b1;
        lidx  = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row[ROWS-1-r]) begin
                lnone = 1'b0;
                lidx  = KW'(r * COLS) + KW'(c_q);
            end
        end

        fnone_d = fnone_q;
        fidx_d  = fidx_q;
        if (sample && !lnone && (fnone_q || lidx < fidx_q)) begin
            fnone_d = 1'b0;
            fidx_d  = lidx;
        end

        same_prev = (fnone_q == pnone_q) && (fnone_q || fidx_q == pidx_q);
        same_deb  = (fnone_q == dnone_q) && (fnone_q || fidx_q == didx_q);

        pnone_d = pnone_q;
        pidx_d  = pidx_q;
        dnone_d = dnone_q;
        didx_d  = didx_q;
        stab_d  = stab_q;
        evt_d   = 1'b0;
        ecode_d = ecode_q;
        if (wrap) begin
            fnone_d = 1'b1;
            fidx_d  = '0;
            pnone_d = fnone_q;
            pidx_d  = fidx_q;
            if (!same_prev) begin
                stab_d = SW'(1);
            end else if (stab_q != SW'(DEBOUNCE_SCANS)) begin
                stab_d = stab_q + SW'(1);
            end
            if (stab_d >= SW'(DEBOUNCE_SCANS) && !same_deb) begin
                dnone_d = fnone_q;
                didx_d  = fidx_q;
                evt_d   = !fnone_q;
                ecode_d = to_code(fidx_q);
            end
        end

        held_d = !dnone_q;

        valid_d = valid_q;
        code_d  = code_q;
        ovr_d   = ovr_q;
        if (evt_q) begin
            if (!valid_q || key_ready) begin
                valid_d = 1'b1;
                code_d  = ecode_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q  <= '0;
            c_q     <= '0;
            col_q   <= '1;
            fnone_q <= 1'b1;
            fidx_q  <= '0;
            pnone_q <= 1'b1;
            pidx_q  <= '0;
            dnone_q <= 1'b1;
            didx_q  <= '0;
            stab_q  <= '0;
            evt_q   <= 1'b0;
            ecode_q <= '0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            c_q     <= c_d;
            col_q   <= col_d;
            fnone_q <= fnone_d;
            fidx_q  <= fidx_d;
            pnone_q <= pnone_d;
            pidx_q  <= pidx_d;
            dnone_q <= dnone_d;
            didx_q  <= didx_d;
            stab_q  <= stab_d;
            evt_q   <= evt_d;
            ecode_q <= ecode_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
        end
    end

    assign col         = col_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_held    = held_q;
    assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: 4x4 matrix, 16-cycle columns, 64-cycle frames.
// Expected key codes go through a scoreboard queue checked on each accept.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_held;
    logic       key_overrun;

    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_evt = 0;
    logic [3:0]  sb[$];

    keypad_scanner #(
        .ROWS(4),
        .COLS(4),
        .SCAN_TICKS(16),
        .SETTLE_TICKS(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held(key_held),
        .key_overrun(key_overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[3-c]) row[3-r] = 1'b0;
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic logic [3:0] exp_code(input int idx);
`ifdef KEYPAD_HEXMAP_EN
        case (idx)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
            4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
            8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
            12: return 4'h0; 13: return 4'hF; 14: return 4'hE; default: return 4'hD;
        endcase
`else
        return 4'(idx);
`endif
    endfunction

    // Scoreboard: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            n_evt++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got code %h, none expected", key_code);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                if (key_code !== e) begin
                    n_fail++;
                    $display("FAIL sb_code: got %h, expected %h", key_code, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        pressed = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests += 5;
        if (col !== 4'b1111) begin n_fail++; $display("FAIL rst_col: got %b, expected 1111", col); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", key_valid); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL rst_held: got %b, expected 0", key_held); end
        if (key_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b, expected 0", key_overrun); end
        if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_code: got %h, expected 0", key_code); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [3:0] one;
        logic [3:0] e;
        bit bad;
        do_reset();
        one = 4'b1000;
        bad = 0;
        for (int k = 1; k <= 128; k++) begin
            wait_cyc(k);
            e = ~(one >> ((k / 16) % 4));
            if (!bad && (col !== e || key_valid !== 1'b0 || key_held !== 1'b0)) begin
                bad = 1;
                $display("FAIL idle_scan: cycle %0d col %b valid %b held %b, expected col %b valid 0 held 0",
                         k, col, key_valid, key_held, e);
            end
        end
        n_tests++;
        if (bad) n_fail++;
    endtask

    task automatic test_press();
        int e0;
        do_reset();
        key_ready = 1'b1;
        pressed[6] = 1'b1;
        sb.push_back(exp_code(6));
        e0 = n_evt;
        wait_cyc(192);
        n_tests++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_early: valid %b, expected 0", key_valid); end
        wait_cyc(193);
        n_tests += 3;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b, expected 1", key_valid); end
        if (key_code !== exp_code(6)) begin n_fail++; $display("FAIL press_code: got %h, expected %h", key_code, exp_code(6)); end
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL press_held: got %b, expected 1", key_held); end
        wait_cyc(320);
        pressed = '0;
        wait_cyc(511);
        n_tests++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL release_early: held %b, expected 1", key_held); end
        wait_cyc(513);
        n_tests += 2;
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL release_held: got %b, expected 0", key_held); end
        if (n_evt - e0 !== 1) begin n_fail++; $display("FAIL press_count: got %0d events, expected 1", n_evt - e0); end
    endtask

    task automatic test_bounce();
        int e0;
        bit seen;
        do_reset();
        key_ready = 1'b1;
        e0 = n_evt;
        seen = 0;
        pressed[13] = 1'b1;
        for (int k = 1; k <= 448; k++) begin
            wait_cyc(k);
            if (k == 128) pressed = '0;
            if (key_held !== 1'b0) seen = 1;
        end
        n_tests += 2;
        if (seen) begin n_fail++; $display("FAIL bounce_held: held went 1, expected 0"); end
        if (n_evt != e0) begin n_fail++; $display("FAIL bounce_evt: got %0d events, expected 0", n_evt - e0); end
    endtask

    task automatic test_overrun();
        do_reset();
        key_ready = 1'b0;
        pressed[15] = 1'b1;
        sb.push_back(exp_code(15));
        wait_cyc(193);
        n_tests += 2;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b, expected 1", key_valid); end
        if (key_code !== exp_code(15)) begin n_fail++; $display("FAIL ovr_code1: got %h, expected %h", key_code, exp_code(15)); end
        wait_cyc(256);
        pressed = '0;
        wait_cyc(448);
        pressed[0] = 1'b1;
        wait_cyc(640);
        n_tests++;
        if (key_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b, expected 0", key_overrun); end
        wait_cyc(641);
        n_tests += 2;
        if (key_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, expected 1", key_overrun); end
        if (key_code !== exp_code(15)) begin n_fail++; $display("FAIL ovr_code2: got %h, expected %h", key_code, exp_code(15)); end
        wait_cyc(650);
        key_ready = 1'b1;
        wait_cyc(652);
        n_tests += 4;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: valid %b, expected 0", key_valid); end
        if (key_code !== exp_code(15)) begin n_fail++; $display("FAIL ovr_code3: got %h, expected %h", key_code, exp_code(15)); end
        if (key_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, expected 1", key_overrun); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL ovr_sb: %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        pressed = '0;
        wait_cyc(704);
        pressed[5] = 1'b1;
        wait_cyc(800);
        n_tests++;
        if (key_held !== 1'b1) begin n_fail++; $display("FAIL mid_pre_held: got %b, expected 1", key_held); end
        rst = 1'b1;
        @(negedge clk);
        n_tests += 5;
        if (col !== 4'b1111) begin n_fail++; $display("FAIL mid_col: got %b, expected 1111", col); end
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b, expected 0", key_valid); end
        if (key_held !== 1'b0) begin n_fail++; $display("FAIL mid_held: got %b, expected 0", key_held); end
        if (key_overrun !== 1'b0) begin n_fail++; $display("FAIL mid_ovr: got %b, expected 0", key_overrun); end
        if (key_code !== 4'h0) begin n_fail++; $display("FAIL mid_code: got %h, expected 0", key_code); end
        rst = 1'b0;
        sb.push_back(exp_code(5));
        wait_cyc(192);
        n_tests++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early: valid %b, expected 0", key_valid); end
        wait_cyc(193);
        n_tests += 2;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL mid_event: valid %b, expected 1", key_valid); end
        if (key_code !== exp_code(5)) begin n_fail++; $display("FAIL mid_evcode: got %h, expected %h", key_code, exp_code(5)); end
        wait_cyc(200);
        pressed = '0;
    endtask

    task automatic test_multi();
        do_reset();
        key_ready = 1'b1;
        pressed[8] = 1'b1;
        pressed[3] = 1'b1;
        sb.push_back(exp_code(3));
        wait_cyc(193);
        n_tests += 2;
        if (key_valid !== 1'b1) begin n_fail++; $display("FAIL multi_valid: got %b, expected 1", key_valid); end
        if (key_code !== exp_code(3)) begin n_fail++; $display("FAIL multi_code: got %h, expected %h", key_code, exp_code(3)); end
        wait_cyc(200);
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL multi_sb: %0d pending, expected 0", sb.size()); end
        pressed = '0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_overrun();
        test_reset_mid();
        test_multi();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner; successor to the fixed 4x4 hex-keypad decoder.
- Drives one column low at a time and samples active-low rows after a settle delay.
- Debounces across full scan frames and emits one key event per debounced press over a valid/ready handshake.
- Sits between the keypad pins and the stack-calculator token consumer.

Parameters:
- ROWS, 4, number of row inputs (>=1).
- COLS, 4, number of column outputs (>=1).
- SCAN_TICKS, 100000, clk cycles each column is driven (> SETTLE_TICKS+1).
- SETTLE_TICKS, 8, cycles after column drive before rows are sampled (>=1).
- DEBOUNCE_SCANS, 3, consecutive identical frames required to accept a key state (>=1).
- KW (derived), clog2(ROWS*COLS) min 1, key code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- row  in  ROWS  keypad rows, active-low.
- col  out  COLS  keypad columns, active-low drive, one-hot-low.
- key_code  out  KW  key of the pending event.
- key_valid  out  1  event pending.
- key_ready  in  1  consumer accepts event.
- key_held  out  1  debounced "some key down" level.
- key_overrun  out  1  sticky: an event was dropped.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - col = all ones.
  - key_code = 0, key_valid = 0, key_held = 0, key_overrun = 0.
  - tick = 0, column index = 0, candidate = NONE, debounced = NONE, stable count = 0.
  - Reset mid-frame discards partial frame data and any pending event.
- Column drive:
  - Column index c is in 0..COLS-1; column c drives col[COLS-1-c] low, all others high.
  - Index 0 is driven on the first cycle after rst deasserts.
  - tick counts 0..SCAN_TICKS-1 per column. At tick==SCAN_TICKS-1, tick wraps, c advances (COLS-1 wraps to 0) and col updates on the same edge.
- Row sampling:
  - At tick==SETTLE_TICKS, row is sampled. Row r is pressed when row[ROWS-1-r]==0.
  - Raw index = r*COLS + c.
  - The frame candidate is the lowest raw index pressed during the frame (multi-key: lowest index wins), else NONE.
- Frame evaluation happens on the cycle c wraps from COLS-1 to 0:
  - If the frame candidate equals the previous frame's candidate, the stable count increments (saturating); otherwise it is set to 1.
  - When the stable count reaches DEBOUNCE_SCANS and the candidate differs from debounced, debounced is updated.
  - key_held = (debounced != NONE), registered one cycle after evaluation.
- Event generation:
  - An event fires when debounced changes to a non-NONE value, i.e. from NONE or from a different key.
  - A release (change to NONE) produces no event.
- Handshake:
  - On an event with key_valid==0, or with key_valid && key_ready in the same cycle: load key_code, key_valid=1 on the next edge. A same-cycle accept plus new event does not set key_overrun.
  - key_valid && key_ready with no event: key_valid=0 next edge.
  - key_code is stable while key_valid=1.
  - Event while key_valid && !key_ready: event dropped, key_code unchanged, key_overrun=1 until rst.
- Latency: a press stable from the start of a frame yields key_valid after DEBOUNCE_SCANS frames, plus 1 cycle. One frame = COLS*SCAN_TICKS cycles.

Optional Feature:
- Macro KEYPAD_HEXMAP_EN.
- Defined: key_code carries the hex legend instead of the raw index, for ROWS=COLS=4 only; other sizes are an elaboration error. Mapping by (r,c):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- Undefined: key_code = raw index r*COLS+c.
- Debounce, priority and handshake are identical in both builds.

Test Plan (ROWS=COLS=4, SCAN_TICKS=16, SETTLE_TICKS=4, DEBOUNCE_SCANS=3, frame=64 cycles; row model pulls the pressed row low while its column is driven):
- Reset then idle, row=4'b1111:
  - col cycles 0111, 1011, 1101, 1110, each held 16 cycles.
  - key_valid=0, key_held=0 throughout.
- Hold key r1c2 from cycle 0, key_ready=1:
  - Exactly one key_valid pulse, about 3 frames after the press.
  - key_code=6 (raw), or 6 with KEYPAD_HEXMAP_EN.
  - key_held=1 while held, returns to 0 three frames after release.
- Press r3c1 for 2 frames only (bounce):
  - No event, key_held stays 0.
- Press r3c3 with key_ready=0, release, then press r0c0:
  - First event stays pending with key_code=15 (raw) / 0xD (hex).
  - Second event dropped, key_overrun=1.
  - key_code is still 15 after key_ready=1 accepts.
- Press r2c0 and r0c3 together:
  - key_code=3 (raw, lowest index) / 0xA (hex).
- Assert rst during frame 2 of a debounce:
  - All outputs return to reset values the next cycle.
  - No event until 3 fresh full frames complete.
